// File: rtl/cic_pkg.sv
// Shared sizing helpers for the CIC interpolator: internal word width and rate constants.
package cic_pkg;

    localparam int DEFAULT_R = 16;
    localparam int LOG2_R    = $clog2(DEFAULT_R);

    // Growth of an N-stage interpolator is R^(N-1), so W adds (N-1)*log2(R) bits to the input.
    function automatic int cic_interp_width(input int bin, input int n, input int r);
        return bin + (n - 1) * $clog2(r);
    endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// One enable-gated two's-complement accumulator; wraps modulo 2^W by design.
module cic_integrator_stage
    import cic_pkg::*;
#(
    parameter int W = 36
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                en_i,
    input  logic signed [W-1:0] data_i,
    output logic signed [W-1:0] acc_o
);

    logic signed [W-1:0] acc_q;
    logic signed [W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            acc_d = acc_q + data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/cic_interpolator_stage.sv
// CIC interpolator: comb chain on the reduced tick, zero-stuffing, N pipelined integrators on the fast tick.
module cic_interpolator_stage
    import cic_pkg::*;
#(
    parameter int NUM_STAGES           = 4,
    parameter int INTERPOLATION_FACTOR = 16,
    parameter int NUM_BITS_IN          = 24,
    parameter int NUM_BITS_OUT         = 24
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           tick_i,
    input  logic                           tick_reduced_i,
    input  logic signed [NUM_BITS_IN-1:0]  signal_i,
    output logic signed [NUM_BITS_OUT-1:0] signal_o,
    output logic                           valid_o,
    output logic                           overrun_o
);

    localparam int W     = cic_interp_width(NUM_BITS_IN, NUM_STAGES, INTERPOLATION_FACTOR);
    localparam int SHIFT = W - NUM_BITS_OUT;

    typedef logic signed [W-1:0] acc_t;

    if (NUM_STAGES < 1) begin : g_bad_n
        $error("cic_interpolator_stage: NUM_STAGES must be >= 1");
    end
    if (INTERPOLATION_FACTOR < 2 ||
        (INTERPOLATION_FACTOR & (INTERPOLATION_FACTOR - 1)) != 0) begin : g_bad_r
        $error("cic_interpolator_stage: INTERPOLATION_FACTOR must be a power of two >= 2");
    end
    if (NUM_BITS_OUT > W) begin : g_bad_out
        $error("cic_interpolator_stage: NUM_BITS_OUT exceeds internal width");
    end

    acc_t                           d_q [NUM_STAGES];
    acc_t                           d_d [NUM_STAGES];
    acc_t                           comb_q, comb_d;
    logic                           pending_q, pending_d;
    logic                           overrun_q, overrun_d;
    logic                           valid_q, valid_d;
    logic signed [NUM_BITS_OUT-1:0] signal_q, signal_d;
    acc_t                           stuffed;
    acc_t                           integ_in  [NUM_STAGES];
    acc_t                           integ_acc [NUM_STAGES];

    always_comb begin
        acc_t c;
        c      = acc_t'(signal_i);
        comb_d = comb_q;
        for (int k = 0; k < NUM_STAGES; k++) begin
            d_d[k] = tick_reduced_i ? c : d_q[k];
            c      = c - d_q[k];
        end
        if (tick_reduced_i) begin
            comb_d = c;
        end
    end

    // A new comb result wins over the clear from a coincident fast tick.
    always_comb begin
        pending_d = pending_q;
        if (tick_reduced_i) begin
            pending_d = 1'b1;
        end else if (tick_i) begin
            pending_d = 1'b0;
        end
        overrun_d = tick_reduced_i & pending_q & ~tick_i;
        valid_d   = tick_i;
        signal_d  = signal_q;
        if (tick_i) begin
            signal_d = NUM_BITS_OUT'(integ_acc[NUM_STAGES-1] >>> SHIFT);
        end
    end

    assign stuffed = pending_q ? comb_q : '0;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_integ
        if (k == 0) begin : g_first
            assign integ_in[k] = stuffed;
        end else begin : g_next
            assign integ_in[k] = integ_acc[k-1];
        end
        cic_integrator_stage #(.W(W)) u_integ (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .en_i    (tick_i),
            .data_i  (integ_in[k]),
            .acc_o   (integ_acc[k])
        );
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                d_q[k] <= '0;
            end
            comb_q    <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            valid_q   <= 1'b0;
            signal_q  <= '0;
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                d_q[k] <= d_d[k];
            end
            comb_q    <= comb_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            valid_q   <= valid_d;
            signal_q  <= signal_d;
        end
    end

    assign signal_o  = signal_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_cic_interpolator_stage.sv
// Bench for cic_interpolator_stage: closed-form impulse-response model plus hand-derived vectors.
module tb_cic_interpolator_stage;

    localparam int N  = 4;
    localparam int W  = 36;
    localparam int SH = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               tick, red;
    logic signed [23:0] sig, dout;
    logic               valid, ovr;

    logic               s_tick, s_red;
    logic signed [23:0] s_sig, s_out;
    logic               s_valid, s_ovr;

    cic_interpolator_stage dut (
        .clk_i(clk), .reset_i(rst), .tick_i(tick), .tick_reduced_i(red),
        .signal_i(sig), .signal_o(dout), .valid_o(valid), .overrun_o(ovr)
    );

    cic_interpolator_stage #(
        .NUM_STAGES(1), .INTERPOLATION_FACTOR(4), .NUM_BITS_IN(24), .NUM_BITS_OUT(24)
    ) dut_small (
        .clk_i(clk), .reset_i(rst), .tick_i(s_tick), .tick_reduced_i(s_red),
        .signal_i(s_sig), .signal_o(s_out), .valid_o(s_valid), .overrun_o(s_ovr)
    );

    int checks = 0;
    int errors = 0;

    // Model state: sample history per reduced tick, stuffed-sample history per fast tick.
    longint             xhist[$];
    longint             uhist[$];
    longint             m_comb;
    bit                 m_pend;
    logic signed [23:0] m_last;
    logic signed [23:0] rec[$];
    int                 vcount;
    int                 ocount;

    typedef struct {
        bit                 red;
        logic signed [23:0] x;
        logic signed [23:0] exp;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint binom(input int n, input int k);
        longint r;
        if (k < 0 || n < k) return 0;
        r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    // N-th order difference of the low-rate sample sequence.
    function automatic longint comb_out();
        longint acc;
        int     idx;
        acc = 0;
        for (int j = 0; j <= N; j++) begin
            idx = xhist.size() - 1 - j;
            if (idx >= 0) begin
                if (j % 2 == 0) acc += binom(N, j) * xhist[idx];
                else            acc -= binom(N, j) * xhist[idx];
            end
        end
        return acc;
    endfunction

    // Last integrator before the current tick's update: weighted sum of past stuffed samples.
    function automatic logic signed [23:0] integ_out();
        longint v;
        int     t;
        t = uhist.size();
        v = 0;
        for (int s = 0; s <= t - N; s++) v += binom(t - 1 - s, N - 1) * uhist[s];
        v = (v <<< (64 - W)) >>> (64 - W);
        v = v >>> SH;
        return v[23:0];
    endfunction

    task automatic model_clear();
        xhist.delete();
        uhist.delete();
        m_comb = 0;
        m_pend = 1'b0;
        m_last = '0;
    endtask

    task automatic cyc(input bit t, input bit r, input logic signed [23:0] x);
        bit exp_ovr;
        tick = t;
        red  = r;
        sig  = x;
        exp_ovr = r && m_pend && !t;
        if (t) begin
            m_last = integ_out();
            uhist.push_back(m_pend ? m_comb : 64'sd0);
            m_pend = 1'b0;
        end
        if (r) begin
            xhist.push_back(longint'(x));
            m_comb = comb_out();
            m_pend = 1'b1;
        end
        @(posedge clk);
        #1;
        tick = 1'b0;
        red  = 1'b0;
        chk("valid", valid, t);
        chk("signal", dout, m_last);
        chk("overrun", ovr, exp_ovr);
        if (valid) vcount++;
        if (ovr) ocount++;
        if (t) rec.push_back(dout);
    endtask

    task automatic do_reset(input bit with_tick);
        rst  = 1'b1;
        tick = with_tick;
        red  = 1'b0;
        @(posedge clk);
        #1;
        tick = 1'b0;
        chk("reset_signal", dout, 0);
        chk("reset_valid", valid, 0);
        chk("reset_overrun", ovr, 0);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic run_dc(input logic signed [23:0] x, input string name);
        int ti;
        for (int i = 0; i < 16 * 10 * 2; i++) begin
            ti = i / 2;
            cyc(i % 2 == 0, (i % 2 == 0) && (ti % 16 == 0), x);
            if ((i % 2 == 0) && ti >= 96) chk(name, dout, x);
        end
    endtask

    initial begin
        logic signed [23:0] xs[8];
        logic signed [23:0] qa[$];
        logic signed [23:0] qb[$];
        int                 n5;
        bit                 m0, m1;
        int                 ti;

        tbl[0]  = '{1'b1, 24'sd5, 24'sd0};
        tbl[1]  = '{1'b0, 24'sd0, 24'sd0};
        tbl[2]  = '{1'b0, 24'sd0, 24'sd5};
        tbl[3]  = '{1'b0, 24'sd0, 24'sd5};
        tbl[4]  = '{1'b1, 24'sd0, 24'sd5};
        tbl[5]  = '{1'b0, 24'sd0, 24'sd5};
        tbl[6]  = '{1'b0, 24'sd0, 24'sd0};
        tbl[7]  = '{1'b0, 24'sd0, 24'sd0};
        tbl[8]  = '{1'b1, 24'sd0, 24'sd0};
        tbl[9]  = '{1'b0, 24'sd0, 24'sd0};
        tbl[10] = '{1'b0, 24'sd0, 24'sd0};
        tbl[11] = '{1'b0, 24'sd0, 24'sd0};
        xs = '{24'sd1000, -24'sd2000, 24'sd3000, 24'sd0,
               24'sd5000, -24'sd7000, 24'sd100, 24'sd42};

        rst = 1'b1; tick = 0; red = 0; sig = '0;
        s_tick = 0; s_red = 0; s_sig = '0;
        vcount = 0; ocount = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_signal", dout, 0);
        chk("rst_valid", valid, 0);
        chk("rst_overrun", ovr, 0);
        chk("rst_small_signal", s_out, 0);
        chk("rst_small_valid", s_valid, 0);
        rst = 1'b0;

        // Zero-order hold on the N=1, R=4 instance.
        n5 = 0;
        for (int i = 0; i < 12; i++) begin
            s_tick = 1'b1;
            s_red  = tbl[i].red;
            s_sig  = tbl[i].x;
            @(posedge clk);
            #1;
            s_tick = 1'b0;
            s_red  = 1'b0;
            chk("zoh_valid", s_valid, 1);
            chk("zoh_signal", s_out, tbl[i].exp);
            chk("zoh_overrun", s_ovr, 0);
            if (s_out == 24'sd5) n5++;
            @(posedge clk);
            #1;
            chk("zoh_idle_valid", s_valid, 0);
            chk("zoh_hold", s_out, tbl[i].exp);
        end
        chk("zoh_count5", n5, 4);

        run_dc(24'sd1000, "dc_1000");
        do_reset(1'b0);
        run_dc(-24'sd8388608, "dc_fullneg");

        // Reduced tick coincident with a fast tick, then 3 cycles after it.
        do_reset(1'b0);
        rec.delete();
        for (int i = 0; i < 16 * 8 * 4; i++) begin
            ti = i / 4;
            cyc(i % 4 == 0, (i % 4 == 0) && (ti % 16 == 0), xs[ti / 16]);
        end
        qa = rec;
        do_reset(1'b0);
        rec.delete();
        for (int i = 0; i < 16 * 8 * 4; i++) begin
            ti = i / 4;
            cyc(i % 4 == 0, (i % 4 == 3) && (ti % 16 == 0), xs[ti / 16]);
        end
        qb = rec;
        chk("align_len", qb.size(), qa.size());
        m0 = 1'b1;
        m1 = 1'b1;
        for (int i = 0; i < qa.size(); i++) begin
            if (qa[i] != qb[i]) m0 = 1'b0;
            if (i + 1 < qb.size() && qb[i + 1] != qa[i]) m1 = 1'b0;
        end
        chk("align_shift_le1", m0 | m1, 1);

        // Two reduced ticks with no fast tick between them.
        do_reset(1'b0);
        vcount = 0;
        ocount = 0;
        cyc(1'b1, 1'b1, 24'sd100);
        cyc(1'b0, 1'b0, 24'sd0);
        cyc(1'b0, 1'b1, 24'sd200);
        chk("overrun_pulse", ovr, 1);
        cyc(1'b0, 1'b0, 24'sd0);
        chk("overrun_clear", ovr, 0);
        for (int i = 0; i < 60; i++) cyc(i % 2 == 0, (i % 32 == 30), 24'sd200);
        chk("overrun_count", ocount, 1);
        chk("overrun_valid_count", vcount, 31);

        // Reset for one cycle mid-stream, then re-settle.
        do_reset(1'b0);
        for (int i = 0; i < 80; i++) cyc(i % 2 == 0, (i % 32 == 0), 24'sd1000);
        do_reset(1'b1);
        run_dc(24'sd1000, "dc_after_reset");

        // Random tick patterns, overruns and full-range samples.
        do_reset(1'b0);
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, 24'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cic_interpolator_stage.md
Name: cic_interpolator_stage

Overview:
- CIC interpolator downstream of the compensated CIC decimator/FIR chain.
- Takes one low-rate sample per reduced tick, zero-stuffs it to the fast tick rate, and runs N comb plus N integrator stages.
- Emits a unity-DC-gain, full-rate signal for the actuator/DAC path.
- Combs run on `tick_reduced_i`; integrators and output run on `tick_i`.

Parameters:
- `NUM_STAGES`, 4: number of comb stages and number of integrator stages (N ≥ 1).
- `INTERPOLATION_FACTOR`, 16: rate change R. Must be a power of two ≥ 2; elaboration error otherwise.
- `NUM_BITS_IN`, 24: signed input width.
- `NUM_BITS_OUT`, 24: signed output width. Must satisfy `NUM_BITS_OUT` ≤ W.

Ports:
- `clk_i`  in  1  system clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `tick_i`  in  1  fast-rate strobe, one cycle wide.
- `tick_reduced_i`  in  1  low-rate strobe, one cycle wide. Nominally coincident with every R-th `tick_i`.
- `signal_i`  in  `NUM_BITS_IN`  signed low-rate sample, sampled when `tick_reduced_i`=1.
- `signal_o`  out  `NUM_BITS_OUT`  signed full-rate output.
- `valid_o`  out  1  one-cycle pulse, the cycle after each `tick_i`.
- `overrun_o`  out  1  one-cycle pulse when a comb sample is overwritten before it is consumed.

Behaviour:
- Single clock `clk_i`. Reset is synchronous and active-high on `reset_i`.
- Reset clears all comb delays, the comb output register, the pending flag, all integrators, `signal_o`=0, `valid_o`=0 and `overrun_o`=0. Reset mid-operation discards all in-flight data; the first sample after release starts from a clean state.
- Internal width: W = `NUM_BITS_IN` + (N−1)·log2(R). All comb and integrator arithmetic is two's complement modulo 2^W. Wrap-around is required and not flagged.
- Comb section, on `tick_reduced_i`:
  - c0 = sign-extended `signal_i`; ck = c(k−1) − dk, with each dk updated to c(k−1).
  - The chain is combinational within the cycle. cN is registered into `comb_q` and `pending` is set.
- Zero-stuffing and integrators, on `tick_i`:
  - u = `comb_q` if `pending`, else 0; `pending` is cleared.
  - Integrators are pipelined on old values: I1 ← I1 + u; Ik ← Ik + I(k−1) for k = 2..N.
  - `signal_o` ← pre-update IN arithmetically shifted right by (W − `NUM_BITS_OUT`). The top `NUM_BITS_OUT` bits give unity DC gain when `NUM_BITS_OUT`=`NUM_BITS_IN`.
  - `valid_o`=1 the following cycle.
- Simultaneous `tick_i` and `tick_reduced_i` in the same cycle:
  - The integrator consumes the old `comb_q`/`pending`.
  - The new comb result loads and `pending` is re-set; the clear from `tick_i` loses.
- Overrun: `tick_reduced_i` while `pending`=1 and `tick_i`=0 → the old sample is overwritten and `overrun_o` pulses the next cycle.
- Latency: a sample consumed on fast tick k first affects `signal_o` as latched on tick k+N, visible one cycle later.
- Between ticks, `signal_o` holds its value.

Decomposition:
- Package `cic_pkg`:
  - function `cic_interp_width(bin, n, r)` returning W;
  - localparam `LOG2_R`;
  - typedef of the signed W-bit accumulator via a parameterised struct/wrapper where the tool supports it, otherwise as a local typedef.
- Sub-module `cic_integrator_stage`: one enable-gated W-bit accumulator, instantiated N times in a generate loop.
- The comb chain stays inline.

Test Plan:
- N=1, R=4, widths 24/24; input 5 on one reduced tick then 0s, reduced tick every 4th fast tick → `signal_o` = 5 for exactly 4 consecutive `valid_o`, then 0 (zero-order hold).
- Defaults; constant input 1000 every 16 fast ticks → after settling (≤ N reduced samples), every `valid_o` shows `signal_o`=1000 exactly.
- Defaults; constant input −8388608 (full-scale negative) → settled output −8388608, no glitch from integrator wrap.
- `tick_reduced_i` coincident with `tick_i` every cycle-aligned 16th tick, versus offset by 3 cycles → identical output sequences, except a constant latency shift ≤ 1 tick.
- Two `tick_reduced_i` pulses with no `tick_i` between → `overrun_o` pulses once, the second sample is used, `valid_o` count is unchanged.
- `reset_i` asserted for 1 cycle mid-stream with input 1000 → next cycle `signal_o`=0, `valid_o`=0; afterwards the step response re-settles to 1000.
